multicycle_ctrl: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 31 +++
 rtl/mc_mem_timer.sv | 25 ++
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath-select encodings for the multi-cycle MIPS-subset controller
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_R, WB_I,
    MEM_ADDR, MEM_READ, MEM_WRITE, WB_MEM, BRANCH, JUMP, ERROR
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  // Successor of DECODE; anything undecodable lands in ERROR.
  function automatic state_e decode_next(input logic [5:0] op);
    return (op == OP_RTYPE)                 ? EXEC_R   :
           (op == OP_ADDIU)                 ? EXEC_I   :
           (op == OP_LW || op == OP_SW)     ? MEM_ADDR :
           (op == OP_BEQ)                   ? BRANCH   :
           (op == OP_J)                     ? JUMP     : ERROR;
  endfunction
endpackage

// File: rtl/mc_mem_timer.sv
// mc_mem_timer: counts stalled memory-request cycles and flags when MEM_TIMEOUT is reached (0 disables)
module mc_mem_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic timeout_o
);
  if (MEM_TIMEOUT > 0) begin : g_tmr
    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    // The cycle that would make the count reach MEM_TIMEOUT is the timeout cycle, unless ready arrives.
    assign timeout_o = mem_req_i && !mem_ready_i && (cnt_q == W'(MEM_TIMEOUT - 1));
    // Count only stalled request cycles; any idle or completing cycle restarts the count.
    always_comb cnt_d = (mem_req_i && !mem_ready_i) ? cnt_q + 1'b1 : '0;
    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
  end else begin : g_off
    assign timeout_o = 1'b0;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multi-cycle MIPS-subset datapath; PERF_CNT_EN adds cycle/instruction counters
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         ALU_OP,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               illegal_op,
  output logic               mem_timeout,
`ifdef PERF_CNT_EN
  output logic [STATE_W-1:0] state_o,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`else
  output logic [STATE_W-1:0] state_o
`endif
);
  state_e state_q, state_d;
  logic   illegal_q, timeout_q, timeout;
  mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst_n(rst_n), .mem_req_i(mem_req), .mem_ready_i(mem_ready), .timeout_o(timeout)
  );
  assign state_o     = STATE_W'(state_q);
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  // Next state and Moore outputs; only FETCH's IR/PC writes follow mem_ready combinationally.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    ALU_OP        = ALU_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    case (state_q)
      IDLE:      state_d = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : timeout ? ERROR : FETCH;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        state_d   = decode_next(opcode);
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        ALU_OP    = ALU_RTYPE;
        state_d   = WB_R;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = WB_I;
      end
      WB_I: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        state_d = mem_ready ? WB_MEM : timeout ? ERROR : MEM_READ;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        state_d = mem_ready ? FETCH : timeout ? ERROR : MEM_WRITE;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALU_OP        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        state_d   = FETCH;
      end
      default:   state_d = ERROR;
    endcase
  end
  // State register plus sticky error flags, all cleared only by reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_q == DECODE && state_d == ERROR);
      timeout_q <= timeout_q | timeout;
    end
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
  // An instruction retires whenever FETCH is re-entered from any state other than IDLE or FETCH itself.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + ((state_q != IDLE && state_q != ERROR) ? 32'd1 : 32'd0);
      instr_cnt_q <= instr_cnt_q + ((state_d == FETCH && state_q != IDLE && state_q != FETCH) ? 32'd1 : 32'd0);
    end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl with directed instruction sequences
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, ALU_OP;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout;
  logic [3:0] state_o;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctl;
    string       tag;
  } exp_t;
  exp_t sb[$];
  multicycle_ctrl #(.MEM_TIMEOUT(4), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALU_OP(ALU_OP), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state_o(state_o)
  );
  always #5 clk = ~clk;
  // Expected controls per state, bit order:
  // {req,we,iord,irw,pcw,pcc,pcs[1:0],asa,asb[1:0],aop[1:0],rdst,m2r,rw}
  function automatic logic [15:0] ctl_of(input state_e s, input logic rdy);
    case (s)
      FETCH:     return {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000};
      DECODE:    return 16'b0000_0000_0110_0000;
      EXEC_R:    return 16'b0000_0000_1001_0000;
      EXEC_I:    return 16'b0000_0000_1100_0000;
      MEM_ADDR:  return 16'b0000_0000_1100_0000;
      WB_R:      return 16'b0000_0000_0000_0101;
      WB_I:      return 16'b0000_0000_0000_0001;
      WB_MEM:    return 16'b0000_0000_0000_0011;
      MEM_READ:  return 16'b1010_0000_0000_0000;
      MEM_WRITE: return 16'b1110_0000_0000_0000;
      BRANCH:    return 16'b0000_0101_1000_1000;
      JUMP:      return 16'b0000_1010_0000_0000;
      default:   return 16'b0;
    endcase
  endfunction
  // Drive one cycle of inputs and queue the response expected before the next rising edge.
  task automatic step(input logic [5:0] op, input logic rdy, input logic rst, input state_e s,
                      input logic ill, input logic tmo, input string tag);
    exp_t e;
    rst_n     = rst;
    opcode    = op;
    mem_ready = rdy;
    e.st  = 4'(s);
    e.ctl = {ctl_of(s, rdy), ill, tmo};
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e   = sb.pop_front();
      act = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
             alu_src_a, alu_src_b, ALU_OP, reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout};
      checks++;
      if (act !== e.ctl || state_o !== e.st) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                 e.tag, state_o, act, e.st, e.ctl);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 1, IDLE, 0, 0, "rel_idle");
    step(OP_RTYPE, 0, 1, FETCH, 0, 0, "r_fetch1");
    step(OP_RTYPE, 0, 1, FETCH, 0, 0, "r_fetch2");
    step(OP_RTYPE, 1, 1, FETCH, 0, 0, "r_fetch3");
    step(OP_RTYPE, 0, 1, DECODE, 0, 0, "r_decode");
    step(OP_RTYPE, 1, 1, EXEC_R, 0, 0, "r_exec");
    step(OP_RTYPE, 0, 1, WB_R, 0, 0, "r_wb");
    step(OP_LW, 0, 1, FETCH, 0, 0, "mid_fetch");
    step(OP_LW, 0, 0, IDLE, 0, 0, "async_rst");
    step(OP_LW, 1, 1, IDLE, 0, 0, "rel_idle2");
    step(OP_LW, 1, 1, FETCH, 0, 0, "lw_fetch");
    step(OP_LW, 1, 1, DECODE, 0, 0, "lw_decode");
    step(OP_LW, 1, 1, MEM_ADDR, 0, 0, "lw_addr");
    step(OP_LW, 1, 1, MEM_READ, 0, 0, "lw_read");
    step(OP_LW, 1, 1, WB_MEM, 0, 0, "lw_wb");
    step(OP_SW, 1, 1, FETCH, 0, 0, "sw_fetch");
    step(OP_SW, 1, 1, DECODE, 0, 0, "sw_decode");
    step(OP_SW, 1, 1, MEM_ADDR, 0, 0, "sw_addr");
    step(OP_SW, 1, 1, MEM_WRITE, 0, 0, "sw_write");
    step(OP_BEQ, 1, 1, FETCH, 0, 0, "beq_fetch");
    step(OP_BEQ, 1, 1, DECODE, 0, 0, "beq_decode");
    step(OP_BEQ, 1, 1, BRANCH, 0, 0, "beq_branch");
    step(OP_J, 1, 1, FETCH, 0, 0, "j_fetch");
    step(OP_J, 1, 1, DECODE, 0, 0, "j_decode");
    step(OP_J, 1, 1, JUMP, 0, 0, "j_jump");
    step(OP_ADDIU, 1, 1, FETCH, 0, 0, "addiu_fetch");
    step(OP_ADDIU, 0, 1, DECODE, 0, 0, "addiu_decode");
    step(OP_ADDIU, 0, 1, EXEC_I, 0, 0, "addiu_exec");
    step(OP_ADDIU, 0, 1, WB_I, 0, 0, "addiu_wb");
    step(OP_LW, 1, 1, FETCH, 0, 0, "late_fetch");
    step(OP_LW, 0, 1, DECODE, 0, 0, "late_decode");
    step(OP_LW, 0, 1, MEM_ADDR, 0, 0, "late_addr");
    step(OP_LW, 0, 1, MEM_READ, 0, 0, "late_stall1");
    step(OP_LW, 0, 1, MEM_READ, 0, 0, "late_stall2");
    step(OP_LW, 0, 1, MEM_READ, 0, 0, "late_stall3");
    step(OP_LW, 1, 1, MEM_READ, 0, 0, "late_ready4");
    step(OP_LW, 0, 1, WB_MEM, 0, 0, "late_wb");
    step(OP_LW, 1, 1, FETCH, 0, 0, "to_fetch");
    step(OP_LW, 0, 1, DECODE, 0, 0, "to_decode");
    step(OP_LW, 0, 1, MEM_ADDR, 0, 0, "to_addr");
    for (int i = 0; i < 4; i++) step(OP_LW, 0, 1, MEM_READ, 0, 0, $sformatf("to_stall%0d", i + 1));
    for (int i = 0; i < 3; i++) step(OP_LW, 1, 1, ERROR, 0, 1, $sformatf("to_error%0d", i));
    step(OP_LW, 0, 0, IDLE, 0, 0, "to_rst");
    step(6'h3f, 1, 1, IDLE, 0, 0, "ill_idle");
    step(6'h3f, 1, 1, FETCH, 0, 0, "ill_fetch");
    step(6'h3f, 1, 1, DECODE, 0, 0, "ill_decode");
    for (int i = 0; i < 20; i++) step(6'h3f, 1'(i), 1, ERROR, 1, 0, $sformatf("ill_hold%0d", i));
    step(6'h3f, 0, 0, IDLE, 0, 0, "ill_rst");
    step(OP_J, 0, 1, IDLE, 0, 0, "ill_rel");
    step(OP_J, 0, 1, FETCH, 0, 0, "ill_refetch");
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
